// File: rtl/instr_stream_loader.sv
// Host-side loader for the NPU instruction memory: streams an image into
// port B, reads it back to verify an XOR checksum, then launches and tracks the NPU.
module instr_stream_loader #(
    parameter int unsigned INSTR_WIDTH      = 32,
    parameter int unsigned INSTR_MEM_AWIDTH = 10,
    parameter int unsigned LAUNCH_CYCLES    = 2
) (
    input  logic                        clk,
    input  logic                        reset_npu,
    input  logic                        start_load,
    input  logic                        stop,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [INSTR_WIDTH-1:0]      s_data,
    input  logic                        s_last,
    output logic                        push_instr_enable,
    output logic [INSTR_MEM_AWIDTH-1:0] push_instr_addr,
    output logic [INSTR_WIDTH-1:0]      push_instruction,
    input  logic [INSTR_WIDTH-1:0]      instr_rdata,
    output logic                        npu_reset,
    output logic                        npu_running,
    output logic                        load_done,
    output logic                        load_error,
    output logic [INSTR_MEM_AWIDTH:0]   load_count
);

    localparam int unsigned AW = INSTR_MEM_AWIDTH;
    localparam int unsigned CW = INSTR_MEM_AWIDTH + 1;
    // verify index runs to count+1, and count may equal DEPTH
    localparam int unsigned VW = INSTR_MEM_AWIDTH + 2;
    localparam int unsigned LW = (LAUNCH_CYCLES > 1) ? $clog2(LAUNCH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_SLOT  = CW'((1 << INSTR_MEM_AWIDTH) - 1);
    localparam logic [LW-1:0] LAUNCH_END = LW'(LAUNCH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_LAUNCH,
        ST_RUN,
        ST_ERROR
    } state_e;

    state_e                  state_q, state_d;
    logic                    s_ready_q, s_ready_d;
    logic                    push_en_q, push_en_d;
    logic [AW-1:0]           push_addr_q, push_addr_d;
    logic [INSTR_WIDTH-1:0]  push_data_q, push_data_d;
    logic                    npu_reset_q, npu_reset_d;
    logic                    npu_running_q, npu_running_d;
    logic                    load_done_q, load_done_d;
    logic                    load_error_q, load_error_d;
    logic [CW-1:0]           count_q, count_d;
    logic [INSTR_WIDTH-1:0]  wcs_q, wcs_d;
    logic [INSTR_WIDTH-1:0]  rcs_q, rcs_d;
    logic [VW-1:0]           vidx_q, vidx_d;
    logic [LW-1:0]           lc_q, lc_d;

    // Next-state and next-output computation for the load/verify/launch sequence
    always_comb begin
        state_d       = state_q;
        s_ready_d     = 1'b0;
        push_en_d     = 1'b0;
        push_addr_d   = '0;
        push_data_d   = push_data_q;
        npu_reset_d   = 1'b1;
        npu_running_d = 1'b0;
        load_done_d   = load_done_q;
        load_error_d  = load_error_q;
        count_d       = count_q;
        wcs_d         = wcs_q;
        rcs_d         = rcs_q;
        vidx_d        = vidx_q;
        lc_d          = lc_q;

        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start_load) begin
                    state_d      = ST_LOAD;
                    s_ready_d    = 1'b1;
                    count_d      = '0;
                    wcs_d        = '0;
                    rcs_d        = '0;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                end
            end
            ST_LOAD: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    push_en_d   = 1'b1;
                    push_addr_d = count_q[AW-1:0];
                    push_data_d = s_data;
                    count_d     = count_q + CW'(1);
                    wcs_d       = wcs_q ^ s_data;
                    if (s_last) begin
                        state_d   = ST_VERIFY;
                        s_ready_d = 1'b0;
                        vidx_d    = '0;
                    end else if (count_q == LAST_SLOT) begin
                        state_d      = ST_ERROR;
                        s_ready_d    = 1'b0;
                        load_error_d = 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                // index 0 is the final write cycle; reads of addr i land at index i+2
                vidx_d = vidx_q + VW'(1);
                if (vidx_q < VW'(count_q)) begin
                    push_addr_d = vidx_q[AW-1:0];
                end
                if (vidx_q >= VW'(2)) begin
                    rcs_d = rcs_q ^ instr_rdata;
                end
                if (vidx_q == VW'(count_q) + VW'(1)) begin
                    if ((rcs_q ^ instr_rdata) == wcs_q) begin
                        state_d     = ST_LAUNCH;
                        load_done_d = 1'b1;
                        lc_d        = '0;
                    end else begin
                        state_d      = ST_ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                if (lc_q == LAUNCH_END) begin
                    state_d       = ST_RUN;
                    npu_reset_d   = 1'b0;
                    npu_running_d = 1'b1;
                end else begin
                    lc_d = lc_q + LW'(1);
                end
            end
            ST_RUN: begin
                npu_reset_d   = 1'b0;
                npu_running_d = 1'b1;
                if (stop) begin
                    state_d       = ST_IDLE;
                    npu_reset_d   = 1'b1;
                    npu_running_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset_npu) begin
            state_q       <= ST_IDLE;
            s_ready_q     <= 1'b0;
            push_en_q     <= 1'b0;
            push_addr_q   <= '0;
            push_data_q   <= '0;
            npu_reset_q   <= 1'b1;
            npu_running_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
            count_q       <= '0;
            wcs_q         <= '0;
            rcs_q         <= '0;
            vidx_q        <= '0;
            lc_q          <= '0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= s_ready_d;
            push_en_q     <= push_en_d;
            push_addr_q   <= push_addr_d;
            push_data_q   <= push_data_d;
            npu_reset_q   <= npu_reset_d;
            npu_running_q <= npu_running_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
            count_q       <= count_d;
            wcs_q         <= wcs_d;
            rcs_q         <= rcs_d;
            vidx_q        <= vidx_d;
            lc_q          <= lc_d;
        end
    end

    assign s_ready           = s_ready_q;
    assign push_instr_enable = push_en_q;
    assign push_instr_addr   = push_addr_q;
    assign push_instruction  = push_data_q;
    assign npu_reset         = npu_reset_q;
    assign npu_running       = npu_running_q;
    assign load_done         = load_done_q;
    assign load_error        = load_error_q;
    assign load_count        = count_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader with a port-B RAM model and a write scoreboard.
module tb_instr_stream_loader;

    localparam int unsigned IW    = 32;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_npu, start_load, stop, s_valid, s_ready, s_last;
    logic [IW-1:0] s_data;
    logic          push_instr_enable;
    logic [AW-1:0] push_instr_addr;
    logic [IW-1:0] push_instruction, instr_rdata;
    logic          npu_reset, npu_running, load_done, load_error;
    logic [AW:0]   load_count;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] img [DEPTH];
    bit            corrupt = 1'b0;
    bit            cmp_on  = 1'b0;
    int            epoch   = 0;
    logic          acc_prev;
    logic [IW-1:0] acc_data;

    always #5 clk = ~clk;

    instr_stream_loader #(
        .INSTR_WIDTH      (IW),
        .INSTR_MEM_AWIDTH (AW),
        .LAUNCH_CYCLES    (2)
    ) dut (
        .clk               (clk),
        .reset_npu         (reset_npu),
        .start_load        (start_load),
        .stop              (stop),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .s_last            (s_last),
        .push_instr_enable (push_instr_enable),
        .push_instr_addr   (push_instr_addr),
        .push_instruction  (push_instruction),
        .instr_rdata       (instr_rdata),
        .npu_reset         (npu_reset),
        .npu_running       (npu_running),
        .load_done         (load_done),
        .load_error        (load_error),
        .load_count        (load_count)
    );

    // Port-B RAM: synchronous write, registered read, optional corruption of addr 2
    always @(posedge clk) begin
        if (push_instr_enable) mem[push_instr_addr] <= push_instruction;
        instr_rdata <= mem[push_instr_addr] ^ ((corrupt && push_instr_addr == 3'd2) ? 32'h1 : 32'h0);
    end

    // Record stream handshakes as the DUT sees them
    always @(posedge clk) begin
        acc_prev <= s_valid && s_ready && !reset_npu;
        acc_data <= s_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted beat must appear as the next contiguous write; no other writes
    int exp_idx    = 0;
    int seen_epoch = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            if (seen_epoch != epoch) begin
                seen_epoch = epoch;
                exp_idx    = 0;
            end
            if (acc_prev) begin
                chk("wr_en", 64'(push_instr_enable), 64'd1);
                chk("wr_addr", 64'(push_instr_addr), 64'(exp_idx));
                chk("wr_data", 64'(push_instruction), 64'(acc_data));
                exp_idx++;
                chk("wr_count", 64'(load_count), 64'(exp_idx));
            end else begin
                chk("no_write", 64'(push_instr_enable), 64'd0);
            end
        end
    end

    // Expected verify outcome: XOR of written words against XOR of what the RAM returns
    function automatic bit model_ok(input int n);
        logic [IW-1:0] w;
        logic [IW-1:0] r;
        w = '0;
        r = '0;
        for (int i = 0; i < n; i++) begin
            w ^= img[i];
            r ^= img[i] ^ ((corrupt && i == 2) ? 32'h1 : 32'h0);
        end
        return w == r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        epoch++;
        tick();
        start_load = 1'b0;
    endtask

    task automatic stream(input int n, input bit gaps, input bit use_last);
        int i     = 0;
        int guard = 0;
        bit hole  = 1'b0;
        bit acc;
        while (i < n && guard < 100) begin
            if (gaps && hole) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = img[i];
                s_last  = use_last && (i == n - 1);
            end
            hole = !hole;
            @(negedge clk);
            acc = s_valid && s_ready;
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (acc) i++;
            guard++;
        end
        if (i < n) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout: accepted %0d want %0d", i, n);
        end
    endtask

    // Readback addresses, then either the launch sequence or the error state
    task automatic check_tail(input int n, input bit ok);
        @(negedge clk);
        chk("last_wr_ready", 64'(s_ready), 64'd0);
        for (int a = 0; a < n; a++) begin
            @(negedge clk);
            chk("ver_addr", 64'(push_instr_addr), 64'(a));
        end
        @(negedge clk);
        chk("ver_trail_rst", 64'(npu_reset), 64'd1);
        @(negedge clk);
        if (ok) begin
            chk("launch_done", 64'(load_done), 64'd1);
            chk("launch_rst1", 64'(npu_reset), 64'd1);
            chk("launch_err", 64'(load_error), 64'd0);
            @(negedge clk);
            chk("launch_rst2", 64'(npu_reset), 64'd1);
            chk("launch_run", 64'(npu_running), 64'd0);
            @(negedge clk);
            chk("run_rst", 64'(npu_reset), 64'd0);
            chk("run_running", 64'(npu_running), 64'd1);
            chk("run_done", 64'(load_done), 64'd1);
            chk("run_count", 64'(load_count), 64'(n));
            chk("run_port_idle", 64'(push_instr_addr), 64'd0);
        end else begin
            chk("err_flag", 64'(load_error), 64'd1);
            chk("err_rst", 64'(npu_reset), 64'd1);
            chk("err_ready", 64'(s_ready), 64'd0);
            chk("err_done", 64'(load_done), 64'd0);
        end
    endtask

    task automatic do_stop();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("stop_running", 64'(npu_running), 64'd0);
        chk("stop_rst", 64'(npu_reset), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        img = '{32'h11, 32'h22, 32'h44, 32'h88,
                32'h0000_1234, 32'hdead_0001, 32'h0bad_f00d, 32'h7777_0008};
        reset_npu  = 1'b1;
        start_load = 1'b0;
        stop       = 1'b0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        s_data     = '0;
        tick();
        tick();
        reset_npu = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_npu_reset", 64'(npu_reset), 64'd1);
        chk("rst_running", 64'(npu_running), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_error", 64'(load_error), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_en", 64'(push_instr_enable), 64'd0);
        chk("rst_addr", 64'(push_instr_addr), 64'd0);
        chk("rst_data", 64'(push_instruction), 64'd0);
        chk("rst_count", 64'(load_count), 64'd0);
        cmp_on = 1'b1;

        // back-to-back 4-word image
        tick();
        pulse_start();
        stream(4, 1'b0, 1'b1);
        check_tail(4, model_ok(4));
        chk("b2b_count", 64'(load_count), 64'd4);

        // stop and start_load together in RUN: stop wins
        tick();
        stop       = 1'b1;
        start_load = 1'b1;
        tick();
        stop       = 1'b0;
        start_load = 1'b0;
        @(negedge clk);
        chk("ss_rst", 64'(npu_reset), 64'd1);
        chk("ss_running", 64'(npu_running), 64'd0);
        chk("ss_done_held", 64'(load_done), 64'd1);
        repeat (3) @(negedge clk);
        chk("ss_no_load_ready", 64'(s_ready), 64'd0);
        chk("ss_no_load_done", 64'(load_done), 64'd1);

        // same image with s_valid toggled every other cycle
        tick();
        pulse_start();
        stream(4, 1'b1, 1'b1);
        check_tail(4, model_ok(4));
        do_stop();

        // corrupted readback of addr 2, then a clean reload from ERROR
        corrupt = 1'b1;
        tick();
        pulse_start();
        stream(4, 1'b0, 1'b1);
        check_tail(4, model_ok(4));
        repeat (3) @(negedge clk);
        chk("err_hold_rst", 64'(npu_reset), 64'd1);
        chk("err_hold_flag", 64'(load_error), 64'd1);
        corrupt = 1'b0;
        tick();
        pulse_start();
        @(negedge clk);
        chk("reload_err_clr", 64'(load_error), 64'd0);
        chk("reload_ready", 64'(s_ready), 64'd1);
        tick();
        stream(4, 1'b0, 1'b1);
        check_tail(4, model_ok(4));
        do_stop();

        // overflow: 8 beats with no s_last into an 8-word memory
        tick();
        pulse_start();
        stream(8, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_addr", 64'(push_instr_addr), 64'd7);
        chk("ovf_count", 64'(load_count), 64'd8);
        chk("ovf_err", 64'(load_error), 64'd1);
        chk("ovf_ready", 64'(s_ready), 64'd0);
        chk("ovf_rst", 64'(npu_reset), 64'd1);
        tick();
        s_valid = 1'b1;
        s_data  = 32'hffff_ffff;
        repeat (3) begin
            @(negedge clk);
            chk("ovf_ready_after", 64'(s_ready), 64'd0);
        end
        s_valid = 1'b0;

        // reset asserted mid-load after two beats
        tick();
        pulse_start();
        stream(2, 1'b0, 1'b0);
        reset_npu = 1'b1;
        s_valid   = 1'b1;
        s_data    = img[2];
        tick();
        reset_npu = 1'b0;
        s_valid   = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_npu", 64'(npu_reset), 64'd1);
        chk("mid_rst_count", 64'(load_count), 64'd0);
        chk("mid_rst_err", 64'(load_error), 64'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_idle", 64'(s_ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Host-side writer for the NPU instruction memory. Drives write port B (push_instr_enable / push_instr_addr / push_instruction), the other end of the NPU's get_instr fetch on port A.
- Accepts a valid/ready instruction stream and writes it from address 0. Reads the image back through port B and checks an XOR checksum.
- Holds the NPU in reset until a verified image is loaded, then releases it and tracks the run.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- INSTR_MEM_AWIDTH, 10, instruction memory address width; DEPTH = 2^INSTR_MEM_AWIDTH.
- LAUNCH_CYCLES, 2, cycles npu_reset stays high after a successful verify.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_npu  in  1  synchronous active-high reset.
- start_load  in  1  single-cycle pulse; begins a load.
- stop  in  1  single-cycle pulse; ends a run.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  stream beat accepted when s_valid && s_ready.
- s_data  in  INSTR_WIDTH  instruction word.
- s_last  in  1  final beat of the image.
- push_instr_enable  out  1  port B write enable.
- push_instr_addr  out  INSTR_MEM_AWIDTH  port B address.
- push_instruction  out  INSTR_WIDTH  port B write data.
- instr_rdata  in  INSTR_WIDTH  port B read data; holds ram[addr] one cycle after addr is presented.
- npu_reset  out  1  reset to the NPU.
- npu_running  out  1  high while the NPU is released.
- load_done  out  1  image loaded and verified.
- load_error  out  1  checksum mismatch or overflow.
- load_count  out  INSTR_MEM_AWIDTH+1  words written by the last load.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; npu_reset=1; every other output 0, including addr, data and count. Internal write checksum wcs and read checksum rcs are 0.
- Reset applied mid-operation aborts immediately to IDLE. Memory contents are left as-is.
- States: IDLE, LOAD, VERIFY, LAUNCH, RUN, ERROR.
- IDLE:
  - s_ready=0; s_valid is ignored.
  - start_load -> LOAD; clears count, wcs, rcs, load_done and load_error.
- LOAD:
  - s_ready=1.
  - On each accepted beat, the next cycle drives push_instr_enable=1, push_instr_addr=count and push_instruction=s_data. Then count+=1 and wcs^=s_data.
  - Back-to-back beats give one write per cycle.
  - push_instr_enable=0 in cycles with no accepted beat.
  - An accepted beat with s_last=1 is written, then the block enters VERIFY; s_ready=0 from the cycle after.
  - An accepted beat at count==DEPTH-1 with s_last=0 is written, count becomes DEPTH, and the block enters ERROR (overflow). A beat with s_last=1 at count==DEPTH-1 is legal.
- VERIFY:
  - push_instr_enable=0.
  - push_instr_addr steps 0..count-1, one per cycle.
  - Each cycle after an address is presented, rcs^=instr_rdata. VERIFY therefore lasts count+1 cycles.
  - Then rcs==wcs -> LAUNCH; otherwise -> ERROR.
- LAUNCH:
  - npu_reset=1 for LAUNCH_CYCLES cycles, then RUN.
  - load_done=1 from LAUNCH entry.
- RUN:
  - npu_reset=0, npu_running=1, load_done=1.
  - The NPU fetches from address 0.
  - Port B outputs stay idle (enable 0, addr 0).
  - stop -> IDLE with npu_reset=1 and npu_running=0 the following cycle. load_done is held until the next start_load.
  - start_load is ignored in RUN. If stop and start_load coincide, stop wins and start_load is dropped.
- ERROR:
  - load_error=1, npu_reset=1, s_ready=0.
  - start_load -> LOAD (clears load_error).
- start_load in LOAD, VERIFY or LAUNCH is ignored.
- load_count updates with every write and holds after the load.

Test Plan:
- Load 4 words 0x11,0x22,0x44,0x88 back-to-back with s_last on beat 4 -> enable high for 4 consecutive cycles at addrs 0..3; VERIFY 5 cycles; npu_reset falls 2 cycles after LAUNCH entry; npu_running=1; load_count=4; load_done=1.
- Same image with s_valid toggled every other cycle -> writes only on accepted beats; addresses contiguous 0..3; identical final state.
- Bench memory model corrupts addr 2 readback (0x44->0x45) -> load_error=1; state ERROR; npu_reset stays 1; later start_load with a clean memory -> successful run.
- INSTR_MEM_AWIDTH=3, stream 8 beats without s_last -> 8 writes; load_count=8; ERROR; s_ready=0 afterwards.
- In RUN, pulse stop and start_load together -> npu_reset=1 and npu_running=0 next cycle; state IDLE; no load begins.
- Assert reset_npu during LOAD after 2 beats -> next cycle: IDLE, npu_reset=1, s_ready=0, load_count=0.
